// File: rtl/linked_list_pop_arbiter.sv
// Round-robin pop arbiter for the shared linked-list FIFO, feeding a 2-entry
// skid buffer that presents a valid/ready stream tagged with the source queue.
module linked_list_pop_arbiter #(
  parameter int WIDTH     = 4,
  parameter int NUM_FIFOS = 1,
  parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [WIDTH-1:0]     data_out,
  input  logic [NUM_FIFOS-1:0] queue_en,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel,
  output logic [1:0]           occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0]     data;
    logic [SEL_WIDTH-1:0] sel;
  } ent_t;

  logic [NUM_FIFOS-1:0] elig;
  logic                 any_elig;
  logic                 xfer;
  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] cand;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0] last_sel_q, last_sel_d;
  ent_t [1:0]           slot_q, slot_d;
  logic [1:0]           occ_q, occ_d;

  assign elig     = ~empty & queue_en;
  assign any_elig = |elig;

  // Scan from the farthest offset down so the nearest eligible queue after
  // rr_ptr wins; rr_ptr itself (offset NUM_FIFOS) has the lowest priority.
  always_comb begin
    grant = '0;
    cand  = '0;
    for (int k = NUM_FIFOS; k >= 1; k--) begin
      cand = SEL_WIDTH'((int'(rr_ptr_q) + k) % NUM_FIFOS);
      if (elig[cand]) grant = cand;
    end
  end

  // Pop is independent of out_ready: a full buffer alone throttles it.
  assign pop       = rst_n & any_elig & (occ_q != 2'd2);
  assign pop_sel   = pop ? grant : last_sel_q;
  assign out_valid = (occ_q != 2'd0);
  assign xfer      = out_valid & out_ready;
  assign out_data  = slot_q[0].data;
  assign out_sel   = slot_q[0].sel;
  assign occupancy = occ_q;

  always_comb begin
    slot_d     = slot_q;
    rr_ptr_d   = rr_ptr_q;
    last_sel_d = last_sel_q;
    if (xfer) slot_d[0] = slot_q[1];
    if (pop) begin
      // New word lands in whichever slot is the tail after this cycle's drain.
      if (occ_q == 2'd0 || (occ_q == 2'd1 && xfer)) slot_d[0] = {data_out, grant};
      else                                           slot_d[1] = {data_out, grant};
      rr_ptr_d   = grant;
      last_sel_d = grant;
    end
    occ_d = occ_q + {1'b0, pop} - {1'b0, xfer};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      occ_q      <= '0;
      rr_ptr_q   <= SEL_WIDTH'(NUM_FIFOS - 1);
      last_sel_q <= '0;
    end else begin
      slot_q     <= slot_d;
      occ_q      <= occ_d;
      rr_ptr_q   <= rr_ptr_d;
      last_sel_q <= last_sel_d;
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty[pop_sel]));
  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
    occ_q <= 2'd2);
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_linked_list_pop_arbiter.sv
// Bench for linked_list_pop_arbiter with three queues: FIFO environment model,
// queue-based reference of the arbiter/buffer, vector table and corner sequences.
module tb_linked_list_pop_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] empty;
  logic [7:0] data_out;
  logic [2:0] queue_en;
  logic       pop;
  logic [1:0] pop_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic [1:0] occupancy;

  int checks = 0;
  int errors = 0;

  linked_list_pop_arbiter #(.WIDTH(8), .NUM_FIFOS(3)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .data_out(data_out),
    .queue_en(queue_en), .pop(pop), .pop_sel(pop_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Shared FIFO environment: per-queue ring storage with head/tail counters.
  logic [7:0] mem [3][64];
  int hd [3];
  int tl [3];

  always_comb begin
    empty = '0;
    for (int i = 0; i < 3; i++) empty[i] = (hd[i] == tl[i]);
  end

  always_comb begin
    data_out = '0;
    if (pop_sel < 2'd3) data_out = mem[pop_sel][6'(hd[pop_sel])];
  end

  // Reference: output buffer as a queue, round-robin pointer, held select.
  typedef struct { logic [7:0] d; logic [1:0] s; } ent_t;
  ent_t mq[$];
  int   m_rr;
  logic [1:0] m_last;

  typedef struct {
    int pre; logic [2:0] qen; logic rdy;
    logic e_pop; logic [1:0] e_sel; logic e_vld; logic [1:0] e_osel; logic [1:0] e_occ;
  } vec_t;
  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int q, input logic [7:0] d);
    mem[q][6'(tl[q])] = d;
    tl[q]++;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 3; i++) begin hd[i] = 0; tl[i] = 0; end
  endtask

  task automatic load(input int q, input int n);
    for (int j = 0; j < n; j++) push(q, 8'(q * 64 + j + 1));
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr   = 2;
    m_last = 2'd0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pop", pop, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step();
    bit el[3];
    int g;
    logic e_pop, xf, p_s;
    logic [1:0] e_sel, ps_s;
    logic [7:0] e_d;
    #1;
    for (int i = 0; i < 3; i++) el[i] = (tl[i] != hd[i]) && queue_en[i];
    g = -1;
    for (int k = 1; k <= 3; k++)
      if (g < 0 && el[(m_rr + k) % 3]) g = (m_rr + k) % 3;
    e_pop = (g >= 0) && (mq.size() < 2);
    e_sel = e_pop ? 2'(g) : m_last;
    chk("pop", pop, e_pop);
    chk("pop_sel", pop_sel, e_sel);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("occupancy", occupancy, mq.size());
    if (mq.size() != 0) begin
      chk("out_data", out_data, mq[0].d);
      chk("out_sel", out_sel, mq[0].s);
    end
    if (pop) chk("pop_while_empty", empty[pop_sel], 0);
    xf  = (mq.size() != 0) && out_ready;
    e_d = '0;
    if (e_pop) e_d = mem[g][6'(hd[g])];
    p_s  = pop;
    ps_s = pop_sel;
    @(posedge clk);
    #1;
    if (xf) void'(mq.pop_front());
    if (e_pop) begin
      mq.push_back('{e_d, 2'(g)});
      m_rr   = g;
      m_last = 2'(g);
    end
    if (p_s && ps_s < 2'd3 && hd[ps_s] < tl[ps_s]) hd[ps_s]++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] got[$];
    int first, last, beats;

    rst_n = 1'b0; queue_en = '0; out_ready = 1'b0;
    clear_fifos();
    for (int q = 0; q < 3; q++) for (int j = 0; j < 64; j++) mem[q][j] = '0;
    model_reset();

    // pre: 1 = reset with all queues loaded, 2 = reset with q1 empty, 3 = refill q1
    tv[0]  = '{1, 3'b111, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0};
    tv[1]  = '{0, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 2'd1};
    tv[2]  = '{0, 3'b111, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1, 2'd1};
    tv[3]  = '{0, 3'b111, 1'b1, 1'b1, 2'd0, 1'b1, 2'd2, 2'd1};
    tv[4]  = '{0, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 2'd1};
    tv[5]  = '{0, 3'b111, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1, 2'd1};
    tv[6]  = '{2, 3'b011, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0};
    tv[7]  = '{0, 3'b011, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 2'd1};
    tv[8]  = '{0, 3'b011, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 2'd1};
    tv[9]  = '{3, 3'b011, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 2'd1};
    tv[10] = '{0, 3'b011, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 2'd1};
    tv[11] = '{0, 3'b011, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 2'd1};
    tv[12] = '{0, 3'b011, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 2'd1};

    @(negedge clk);

    for (int r = 0; r < 13; r++) begin
      queue_en  = tv[r].qen;
      out_ready = tv[r].rdy;
      if (tv[r].pre == 1) begin
        clear_fifos(); for (int q = 0; q < 3; q++) load(q, 20);
        do_reset();
      end else if (tv[r].pre == 2) begin
        clear_fifos(); load(0, 10); load(2, 10);
        do_reset();
      end else if (tv[r].pre == 3) begin
        load(1, 8);
      end
      #1;
      chk($sformatf("vec%0d_pop", r), pop, tv[r].e_pop);
      chk($sformatf("vec%0d_pop_sel", r), pop_sel, tv[r].e_sel);
      chk($sformatf("vec%0d_out_valid", r), out_valid, tv[r].e_vld);
      chk($sformatf("vec%0d_occupancy", r), occupancy, tv[r].e_occ);
      if (tv[r].e_vld) chk($sformatf("vec%0d_out_sel", r), out_sel, tv[r].e_osel);
      step();
    end

    // Backpressure: A,B fill the buffer, C waits until the head drains.
    clear_fifos(); push(0, 8'hA1); push(0, 8'hB2); push(0, 8'hC3);
    queue_en = 3'b001; out_ready = 1'b0;
    do_reset();
    step(); step();
    #1;
    chk("bp_occ_full", occupancy, 2);
    chk("bp_pop_blocked", pop, 0);
    chk("bp_head", out_data, 8'hA1);
    step();
    #1;
    chk("bp_head_held", out_data, 8'hA1);
    chk("bp_sel_held", out_sel, 0);
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) got.push_back(out_data);
      step();
    end
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_order0", got[0], 8'hA1);
      chk("bp_order1", got[1], 8'hB2);
      chk("bp_order2", got[2], 8'hC3);
    end

    // Throughput: 8 words from queue 1 stream back to back.
    clear_fifos(); load(1, 8);
    queue_en = 3'b111; out_ready = 1'b1;
    do_reset();
    first = -1; last = -1; beats = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        beats++;
      end
      step();
    end
    chk("tput_beats", beats, 8);
    chk("tput_span", last - first, 7);
    chk("tput_first_latency", first, 1);

    // Mid-stream reset at full occupancy.
    clear_fifos(); for (int q = 0; q < 3; q++) load(q, 10);
    queue_en = 3'b111; out_ready = 1'b0;
    do_reset();
    step(); step();
    #1;
    chk("mrst_pre_occ", occupancy, 2);
    rst_n = 1'b0;
    #1;
    chk("mrst_async_valid", out_valid, 0);
    chk("mrst_async_occ", occupancy, 0);
    chk("mrst_async_pop", pop, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("mrst_next_pop", pop, 1);
    chk("mrst_next_grant", pop_sel, 0);
    step();

    // Randomized traffic against the reference.
    for (int c = 0; c < 600; c++) begin
      for (int q = 0; q < 3; q++)
        if ($urandom_range(2) == 0 && tl[q] - hd[q] < 60) push(q, 8'($urandom));
      if ($urandom_range(7) == 0) queue_en = 3'($urandom);
      out_ready = ($urandom_range(3) != 0);
      if (c == 300) do_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
